// File: rtl/global_buffer_banked_if.sv
// -----------------------------------------------------------------------------
// global_buffer_banked_if
// Host-side bundle for the banked global buffer.
//   master : the host (drives requests, clear start; observes read data/status)
//   slave  : the buffer itself
// Signals:
//   ram_en, wr_en        access request / direction (1 = write)
//   bank_sel, index      target bank and entry within the bank
//   data_in, byte_we     write data and per-byte write mask
//   data_out, rd_valid   registered read data and its one-cycle valid pulse
//   clr_start            request a clear of every bank
//   clr_busy, clr_done   clear in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
interface global_buffer_banked_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32,
    parameter int BANKS     = 4
);
    localparam int BANK_BITS = $clog2(BANKS);
    localparam int BE_BITS   = DATA_BITS / 8;

    logic                 ram_en;
    logic                 wr_en;
    logic [BANK_BITS-1:0] bank_sel;
    logic [ADDR_BITS-1:0] index;
    logic [DATA_BITS-1:0] data_in;
    logic [BE_BITS-1:0]   byte_we;
    logic [DATA_BITS-1:0] data_out;
    logic                 rd_valid;
    logic                 clr_start;
    logic                 clr_busy;
    logic                 clr_done;

    modport master (
        output ram_en, wr_en, bank_sel, index, data_in, byte_we, clr_start,
        input  data_out, rd_valid, clr_busy, clr_done
    );

    modport slave (
        input  ram_en, wr_en, bank_sel, index, data_in, byte_we, clr_start,
        output data_out, rd_valid, clr_busy, clr_done
    );
endinterface

// File: rtl/global_buffer_banked.sv
// -----------------------------------------------------------------------------
// global_buffer_banked
// Multi-bank, byte-maskable global buffer with one host port, a registered read
// path and an optional hardware clear engine that zeroes every bank in
// DEPTH cycles (one entry of all banks per cycle).
//
// Build option: define GBUFF_CLEAR_EN to build the clear FSM. Without it the
// clr_* ports remain, clr_busy/clr_done read 0 and clr_start is ignored.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (memory contents are not reset)
//   bus    global_buffer_banked_if.slave (host request/response + clear)
// -----------------------------------------------------------------------------
module global_buffer_banked #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32,
    parameter int BANKS     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    global_buffer_banked_if.slave         bus
);
    localparam int DEPTH     = 2 ** ADDR_BITS;
    localparam int BANK_BITS = $clog2(BANKS);
    localparam int BE_BITS   = DATA_BITS / 8;

    logic                 clr_busy;
    logic                 clr_done;
    logic                 clr_wr;
    logic [ADDR_BITS-1:0] clr_ptr;

`ifdef GBUFF_CLEAR_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [ADDR_BITS-1:0] clr_ptr_reg, clr_ptr_next;

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    state_next   = ST_CLEAR;
                    clr_ptr_next = '0;
                end
            end
            ST_CLEAR: begin
                clr_ptr_next = clr_ptr_reg + 1'b1;
                // Last entry is being zeroed at this edge.
                if (&clr_ptr_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    assign clr_busy = (state_reg == ST_CLEAR);
    assign clr_done = (state_reg == ST_DONE);
    assign clr_wr   = clr_busy;
    assign clr_ptr  = clr_ptr_reg;
`else
    // Keeps the unused request visible to lint without building any logic.
    logic unused_clr_start;
    assign unused_clr_start = bus.clr_start;

    assign clr_busy = 1'b0;
    assign clr_done = 1'b0;
    assign clr_wr   = 1'b0;
    assign clr_ptr  = '0;
`endif

    // Host accesses are dropped entirely while the clear engine owns the banks.
    logic host_wr;
    logic host_rd;
    assign host_wr = bus.ram_en &&  bus.wr_en && !clr_busy;
    assign host_rd = bus.ram_en && !bus.wr_en && !clr_busy;

    // Per-bank read registers, exported for the output mux.
    logic [DATA_BITS-1:0] bank_rd [BANKS];

    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
        logic [DATA_BITS-1:0] mem [DEPTH];
        logic [DATA_BITS-1:0] rd_q_reg;
        logic                 sel;

        assign sel = (bus.bank_sel == BANK_BITS'(gi));

        always_ff @(posedge clk) begin
            if (clr_wr) begin
                mem[clr_ptr] <= '0;
            end else if (host_wr && sel) begin
                for (int k = 0; k < BE_BITS; k++) begin
                    if (bus.byte_we[k]) begin
                        mem[bus.index][8*k +: 8] <= bus.data_in[8*k +: 8];
                    end
                end
            end
            // Loaded only on a read of this bank, so it holds the last
            // result for this bank across writes and idle cycles.
            if (host_rd && sel) begin
                rd_q_reg <= mem[bus.index];
            end
        end

        assign bank_rd[gi] = rd_q_reg;
    end

    // Resettable tracking of which bank produced the latest read. The RAM
    // output registers are not resettable, so data_out is forced to zero
    // until the first read after reset.
    logic                 rd_valid_reg;
    logic                 rd_loaded_reg;
    logic [BANK_BITS-1:0] rd_bank_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg  <= 1'b0;
            rd_loaded_reg <= 1'b0;
            rd_bank_reg   <= '0;
        end else begin
            rd_valid_reg <= host_rd;
            if (host_rd) begin
                rd_loaded_reg <= 1'b1;
                rd_bank_reg   <= bus.bank_sel;
            end
        end
    end

    assign bus.data_out = rd_loaded_reg ? bank_rd[rd_bank_reg] : '0;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;
endmodule

// File: doc/global_buffer_banked.md
# global_buffer_banked

Multi-bank, byte-maskable on-chip global buffer with a registered read port and a built-in clear engine. It is the parametrised successor to the single-bank global buffer. The accelerator's A/B/C operand and result staging uses it wherever several independent buffers were previously instantiated side by side. One host port reaches any bank; the optional clear engine zeroes every bank in hardware between layers, with no host write loop.

## Interface
- ADDR_BITS, 8, address bits per bank; DEPTH = 2**ADDR_BITS entries per bank
- DATA_BITS, 32, entry width; must be a multiple of 8
- BANKS, 4, bank count; power of two, >= 2; BANK_BITS = log2(BANKS)
- BE_BITS (derived), DATA_BITS/8, one write-enable bit per byte

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ram_en  in  1  host access request this cycle
- wr_en  in  1  1 = write, 0 = read; qualified by ram_en
- bank_sel  in  BANK_BITS  target bank
- index  in  ADDR_BITS  entry within bank
- data_in  in  DATA_BITS  write data
- byte_we  in  BE_BITS  byte write mask; bit k covers data_in[8k+7:8k]
- data_out  out  DATA_BITS  registered read data
- rd_valid  out  1  one-cycle pulse: data_out was updated by a read
- clr_start  in  1  request a full clear of all banks
- clr_busy  out  1  clear in progress; host accesses ignored
- clr_done  out  1  one-cycle pulse when a clear completes

## Operation
- Reset values: data_out=0, rd_valid=0, clr_busy=0, clr_done=0, FSM=IDLE, clear pointer=0. Memory contents are not reset.
- Write: ram_en=1, wr_en=1, clr_busy=0 → at the edge, bytes k with byte_we[k]=1 of bank[bank_sel][index] take data_in bytes. Other bytes are unchanged. byte_we=0 is a legal no-op.
- Read: ram_en=1, wr_en=0, clr_busy=0 → at the edge, data_out <= bank[bank_sel][index] and rd_valid=1 for one cycle.
- No read → rd_valid=0 and data_out holds its last value (not zeroed).
- Single port: read and write are mutually exclusive per cycle, so there is no read/write collision case.
- Clear FSM states:
  - IDLE: clr_start=1 at an edge → CLEAR, pointer=0. A host access sampled at the same edge still executes.
  - CLEAR: each edge writes 0 to entry [pointer] of every bank at once, then pointer+1. At the edge that writes entry DEPTH-1 → DONE.
  - DONE: one cycle; clr_done=1 → IDLE. Host accesses are allowed in DONE.
- clr_busy = (state==CLEAR).
- While CLEAR: host writes are dropped, reads give no rd_valid, and data_out holds.
- clr_start in CLEAR or DONE is ignored; there is no queueing.
- Reset asserted mid-clear aborts immediately. Entries already zeroed stay zero; the rest keep old contents. FSM goes to IDLE.
- Out-of-range cases cannot occur: bank_sel and index are exactly sized.

## Timing
- Read latency: 1 cycle. Request sampled at edge T; data_out/rd_valid valid after edge T and until edge T+1.
- Write visible to a read requested the following cycle.
- Back-to-back reads give one result per cycle; rd_valid stays high continuously.
- Clear: clr_start sampled at edge T. clr_busy is high after T for exactly DEPTH cycles. clr_done is high for the 1 cycle after that. The first host access is accepted at the edge ending the DONE cycle.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- GBUFF_CLEAR_EN defined: clear FSM, pointer, and per-bank zero-write path are built as above.
- GBUFF_CLEAR_EN undefined:
  - No FSM logic is built; the ports remain.
  - clr_busy and clr_done are tied to 0, and clr_start is ignored.
  - Host accesses are always accepted.

## Test plan
Benches use BANKS=4, ADDR_BITS=4, DATA_BITS=32.
- Write 0xDEADBEEF to bank 2 idx 5 with byte_we=0xF, then read bank 2 idx 5 → next cycle data_out=0xDEADBEEF, rd_valid=1 for 1 cycle.
- Partial write over that entry: byte_we=0x5, data_in=0x11223344 → read returns 0xDE22BE44. Banks 0, 1, 3 idx 5 are unchanged.
- Read banks 0..3 idx 0 on 4 consecutive cycles, each preloaded with 0x10+bank → data_out 0x10, 0x11, 0x12, 0x13 on consecutive cycles, rd_valid high for 4 cycles, then data_out holds 0x13 with rd_valid=0.
- clr_start with all entries preloaded nonzero, plus a write to bank 1 idx 3 issued mid-clear:
  - clr_busy high exactly 16 cycles, then clr_done high 1 cycle.
  - The mid-clear write is dropped.
  - After clr_done, every bank/idx reads 0.
- rst_n pulsed low after 6 clear cycles → clr_busy=0 and data_out=0 immediately. Idx 0..5 read 0 and idx 6..15 keep the preload.
- Build without GBUFF_CLEAR_EN and pulse clr_start → clr_busy and clr_done stay 0, and a write in the same cycle succeeds.
